pc_gen: RTL
===========

Name: pc_gen

Overview:
- Parametrised fetch-PC unit that replaces the combinational next-PC mux with a registered PC.
- Selects the next PC by priority: exception request, ERET, jump/branch redirect, buffered redirect, sequential.
- Buffers a redirect that arrives while fetch is stalled, so it is never lost.
- Flags fetch address faults (misaligned or outside the text segment) for the F-stage exception logic.

Parameters:
- WIDTH, 32, PC/address width in bits.
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- EXC_VEC, 32'h0000_4180, exception/interrupt handler entry.
- PC_STEP, 4, sequential increment.
- TEXT_BASE, 32'h0000_3000, lowest legal fetch address (inclusive).
- TEXT_LIMIT, 32'h0000_6FFC, highest legal fetch address (inclusive).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  freeze the F stage; PC holds.
- req  in  1  exception/interrupt taken (from CP0); highest priority.
- eret_en  in  1  ERET redirect valid.
- epc  in  WIDTH  ERET target.
- jump_en  in  1  branch/jump redirect valid.
- jump_target  in  WIDTH  branch/jump target.
- pc  out  WIDTH  current fetch PC (registered).
- pc_plus8  out  WIDTH  pc + 2*PC_STEP, combinational (link address).
- fetch_fault  out  1  pc misaligned or outside [TEXT_BASE, TEXT_LIMIT], combinational from pc.
- redirect_pending  out  1  a buffered redirect is waiting.

Behaviour:
- State: pc_q (WIDTH), pend_valid (1), pend_is_eret (1), pend_target (WIDTH).
- Reset (synchronous, active-high; overrides everything including req):
  - pc_q = RESET_PC, pend_valid = 0, pend_is_eret = 0, pend_target = 0.
  - Outputs after reset: pc = RESET_PC, pc_plus8 = RESET_PC+8, fetch_fault = 0 (for default parameters), redirect_pending = 0.
- Update rule per cycle, first match wins:
  1. req=1: pc_q <= EXC_VEC regardless of stall; pend_valid <= 0.
  2. stall=1: pc_q holds. Redirect capture:
     - eret_en=1: pend <= {1, eret, epc}; overwrites any pending entry.
     - else jump_en=1: pend <= {1, jump, jump_target}, but only if no pending ERET; a pending jump is overwritten (newest wins).
     - else pend unchanged.
  3. stall=0, eret_en=1: pc_q <= epc; pend_valid <= 0.
  4. stall=0, jump_en=1: pc_q <= jump_target; pend_valid <= 0.
  5. stall=0, pend_valid=1: pc_q <= pend_target; pend_valid <= 0.
  6. Otherwise: pc_q <= pc_q + PC_STEP.
- Latency: a redirect on an unstalled cycle appears on pc the next cycle. A redirect captured during a stall appears one cycle after stall deasserts.
- Arithmetic: all additions are modulo 2^WIDTH. pc_q = 2^WIDTH - 4 steps to 0 with no special handling; fetch_fault flags that case.
- fetch_fault = (pc[1:0] != 0) | (pc < TEXT_BASE) | (pc > TEXT_LIMIT). Comparisons are unsigned. The block only reports the fault; it never redirects itself, and the fault is raised by CP0 through req.
- Targets are loaded unmodified, including misaligned values; the fault is reported when that value is on pc.
- eret_en and jump_en together: ERET wins; the jump is dropped.
- req together with any redirect or pending entry: EXC_VEC wins; all are dropped and pending is cleared.
- redirect_pending = pend_valid.

Test Plan:
- Reset then 3 free cycles -> pc = 3000, 3004, 3008, 300C; fetch_fault = 0; pc_plus8 = 3014 while pc = 300C.
- jump_en=1, jump_target=3400, no stall -> next pc = 3400, then 3404.
- stall high 3 cycles with jump_en pulse (target 3500) in cycle 1 -> pc holds and redirect_pending = 1. Release stall -> pc = 3500 next cycle and redirect_pending = 0.
- During stall: eret_en (epc=3600), then jump_en (target 3700) -> pending stays 3600. Release -> pc = 3600.
- req=1 with stall=1, eret_en=1 and a pending entry -> next pc = 4180, redirect_pending = 0.
- jump_target=3402 -> pc = 3402 with fetch_fault = 1. jump_target=2FFC -> fetch_fault = 1. pc=6FFC -> fetch_fault = 0, then at 7000 fetch_fault = 1. reset asserted mid-stall with a pending entry -> pc = 3000, pending cleared.

Source files
------------

// File: rtl/pc_gen.sv
// Registered fetch-PC generator: prioritised next-PC selection, a one-entry redirect
// buffer that holds a redirect arriving during a stall, and fetch-address fault flagging.
module pc_gen #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = 32'h0000_3000,
  parameter logic [WIDTH-1:0] EXC_VEC    = 32'h0000_4180,
  parameter int               PC_STEP    = 4,
  parameter logic [WIDTH-1:0] TEXT_BASE  = 32'h0000_3000,
  parameter logic [WIDTH-1:0] TEXT_LIMIT = 32'h0000_6FFC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             req,
  input  logic             eret_en,
  input  logic [WIDTH-1:0] epc,
  input  logic             jump_en,
  input  logic [WIDTH-1:0] jump_target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus8,
  output logic             fetch_fault,
  output logic             redirect_pending
);

  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(PC_STEP);
  localparam logic [WIDTH-1:0] STEP2_W = WIDTH'(2 * PC_STEP);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             pend_valid_q, pend_valid_d;
  logic             pend_is_eret_q, pend_is_eret_d;
  logic [WIDTH-1:0] pend_target_q, pend_target_d;

  // Next-state selection: exception, stall capture, ERET, jump, buffered, sequential.
  always_comb begin
    pc_d           = pc_q;
    pend_valid_d   = pend_valid_q;
    pend_is_eret_d = pend_is_eret_q;
    pend_target_d  = pend_target_q;
    if (req) begin
      pc_d         = EXC_VEC;
      pend_valid_d = 1'b0;
    end else if (stall) begin
      // A buffered ERET must not be displaced by a later jump; a buffered jump may be.
      if (eret_en) begin
        pend_valid_d   = 1'b1;
        pend_is_eret_d = 1'b1;
        pend_target_d  = epc;
      end else if (jump_en && !(pend_valid_q && pend_is_eret_q)) begin
        pend_valid_d   = 1'b1;
        pend_is_eret_d = 1'b0;
        pend_target_d  = jump_target;
      end else begin
        pend_valid_d   = pend_valid_q;
      end
    end else if (eret_en) begin
      pc_d         = epc;
      pend_valid_d = 1'b0;
    end else if (jump_en) begin
      pc_d         = jump_target;
      pend_valid_d = 1'b0;
    end else if (pend_valid_q) begin
      pc_d         = pend_target_q;
      pend_valid_d = 1'b0;
    end else begin
      pc_d         = pc_q + STEP_W;
    end
  end

  // State registers with synchronous reset taking precedence over every request.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q           <= RESET_PC;
      pend_valid_q   <= 1'b0;
      pend_is_eret_q <= 1'b0;
      pend_target_q  <= '0;
    end else begin
      pc_q           <= pc_d;
      pend_valid_q   <= pend_valid_d;
      pend_is_eret_q <= pend_is_eret_d;
      pend_target_q  <= pend_target_d;
    end
  end

  assign pc               = pc_q;
  assign pc_plus8         = pc_q + STEP2_W;
  assign fetch_fault      = (pc_q[1:0] != 2'b00) | (pc_q < TEXT_BASE) | (pc_q > TEXT_LIMIT);
  assign redirect_pending = pend_valid_q;

endmodule
